// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Single-outstanding, fixed-latency memory responder. It accepts
//            one read or write request, waits LATENCY cycles, then completes
//            the access against a word-addressed storage array and issues a
//            one-cycle response strobe.
//
// Ports    : clock          - single rising-edge clock
//            reset          - synchronous active-high reset
//            w_req_valid    - requester presents a request
//            w_req_ready    - responder can accept a request (state IDLE)
//            w_rw           - access type, 0 = write, 1 = read
//            w_addr_32      - byte address of the access
//            w_data_in_32   - write data
//            w_resp_valid   - one-cycle response strobe
//            w_data_out_32  - read data (0 for writes and illegal accesses)
//            w_err          - responded request was illegal
//            w_req_count_32 - number of accepted requests (wraps)
//
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h80020000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2      // legal range 1..4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        w_req_valid,
    output logic        w_req_ready,
    input  logic        w_rw,
    input  logic [31:0] w_addr_32,
    input  logic [31:0] w_data_in_32,
    output logic        w_resp_valid,
    output logic [31:0] w_data_out_32,
    output logic        w_err,
    output logic [31:0] w_req_count_32
);

    // ------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------
    localparam int         c_IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [1:0] c_LAT_LOAD = 2'(LATENCY - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q,      state_d;
    logic [1:0]  cnt_q,        cnt_d;
    logic        rw_q,         rw_d;
    logic [31:0] addr_q,       addr_d;
    logic [31:0] wdata_q,      wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] data_out_q,   data_out_d;
    logic        err_q,        err_d;
    logic [31:0] count_q,      count_d;

    // Storage is intentionally excluded from reset so contents survive it.
    logic [31:0] mem_q [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Address decode on the latched request
    // ------------------------------------------------------------------
    logic [31:0]        w_offset;
    logic [31:0]        w_index;
    logic [c_IDX_W-1:0] w_mem_idx;
    logic               w_legal;
    logic               w_complete;
    logic               w_mem_we;
    logic [31:0]        w_rd_data;

    // Subtraction wraps modulo 2^32, so addresses below BASE_ADDR land on a
    // huge index and are rejected by the range compare.
    assign w_offset   = addr_q - BASE_ADDR;
    assign w_index    = {2'b00, w_offset[31:2]};
    assign w_mem_idx  = w_index[c_IDX_W-1:0];
    assign w_legal    = (addr_q[1:0] == 2'b00) && (w_index < 32'(DEPTH_WORDS));
    assign w_complete = (state_q == WAIT) && (cnt_q == 2'd0);

    // A reset on the completion edge must drop the write as well.
    assign w_mem_we   = w_complete && w_legal && !rw_q && !reset;

    // Only meaningful when w_legal; gated below so an out-of-range index
    // on a non-power-of-two depth never reaches the output.
    assign w_rd_data  = mem_q[w_mem_idx];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        data_out_d   = data_out_q;
        err_d        = err_q;
        count_d      = count_q;

        case (state_q)
            IDLE: begin
                if (w_req_valid) begin
                    rw_d    = w_rw;
                    addr_d  = w_addr_32;
                    wdata_d = w_data_in_32;
                    cnt_d   = c_LAT_LOAD;
                    state_d = WAIT;
                    count_d = count_q + 32'd1;
                end
            end

            WAIT: begin
                // Inputs are ignored here; only the counter advances.
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    err_d        = !w_legal;
                    data_out_d   = (w_legal && rw_q) ? w_rd_data : 32'd0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            rw_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            data_out_q   <= 32'd0;
            err_q        <= 1'b0;
            count_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            data_out_q   <= data_out_d;
            err_q        <= err_d;
            count_q      <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage write port
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            mem_q[w_mem_idx] <= wdata_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_req_ready    = (state_q == IDLE);
    assign w_resp_valid   = resp_valid_q;
    assign w_data_out_32  = data_out_q;
    assign w_err          = err_q;
    assign w_req_count_32 = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder. The LATENCY=2 instance is
//            the main target; LATENCY=1 and LATENCY=4 instances share its
//            inputs for the response-timing checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;

    logic        ready1, rv1, err1;
    logic [31:0] dout1, cnt1;
    logic        ready2, rv2, err2;
    logic [31:0] dout2, cnt2;
    logic        ready4, rv4, err4;
    logic [31:0] dout4, cnt4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int resp_cnt = 0;
    int exp_cnt  = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } sb_t;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    sb_t sb[$];
    sb_t mon_e;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mem_responder #(.LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .w_req_valid(req_valid), .w_req_ready(ready1),
        .w_rw(rw), .w_addr_32(addr), .w_data_in_32(wdata), .w_resp_valid(rv1),
        .w_data_out_32(dout1), .w_err(err1), .w_req_count_32(cnt1)
    );
    mem_responder #(.LATENCY(2)) dut2 (
        .clock(clock), .reset(reset), .w_req_valid(req_valid), .w_req_ready(ready2),
        .w_rw(rw), .w_addr_32(addr), .w_data_in_32(wdata), .w_resp_valid(rv2),
        .w_data_out_32(dout2), .w_err(err2), .w_req_count_32(cnt2)
    );
    mem_responder #(.LATENCY(4)) dut4 (
        .clock(clock), .reset(reset), .w_req_valid(req_valid), .w_req_ready(ready4),
        .w_rw(rw), .w_addr_32(addr), .w_data_in_32(wdata), .w_resp_valid(rv4),
        .w_data_out_32(dout4), .w_err(err4), .w_req_count_32(cnt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard consumer for the LATENCY=2 instance.
    always @(negedge clock) begin
        if (!reset && rv2) begin
            resp_cnt++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp: got data=%h err=%b, required no response", dout2, err2);
            end else begin
                mon_e = sb.pop_front();
                if (dout2 !== mon_e.data || err2 !== mon_e.err || cyc != mon_e.acc + 2) begin
                    failures++;
                    $display("FAIL resp: got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d",
                             dout2, err2, cyc, mon_e.data, mon_e.err, mon_e.acc + 2);
                end
            end
        end
    end

    task automatic do_req(input logic r, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] ed, input logic ee);
        int n;
        n = 0;
        @(negedge clock);
        while (!ready2 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!ready2) begin
            failures++;
            $display("FAIL req_ready_timeout: got ready=0 required 1");
        end else begin
            rw = r; addr = a; wdata = d; req_valid = 1'b1;
            sb.push_back('{ed, ee, cyc + 1});
            exp_cnt++;
            @(negedge clock);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clock);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    vec_t tbl[16];
    int   acc;
    int   rc;

    initial begin
        tbl[0]  = '{1'b0, 32'h80020000, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 32'h80020000, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b0, 32'h800203FC, 32'hA5A55A5A, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 32'h800203FC, 32'h0,        32'hA5A55A5A, 1'b0};
        tbl[4]  = '{1'b0, 32'h80020004, 32'h11112222, 32'h0,        1'b0};
        tbl[5]  = '{1'b1, 32'h80020002, 32'h0,        32'h0,        1'b1};
        tbl[6]  = '{1'b1, 32'h80020400, 32'h0,        32'h0,        1'b1};
        tbl[7]  = '{1'b1, 32'h8001FFFC, 32'h0,        32'h0,        1'b1};
        tbl[8]  = '{1'b0, 32'h80020400, 32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[9]  = '{1'b0, 32'h8001FFFC, 32'h0BADBAD0, 32'h0,        1'b1};
        tbl[10] = '{1'b0, 32'h80020006, 32'h77777777, 32'h0,        1'b1};
        tbl[11] = '{1'b1, 32'h80020004, 32'h0,        32'h11112222, 1'b0};
        tbl[12] = '{1'b1, 32'h80020000, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[13] = '{1'b1, 32'h800203FC, 32'h0,        32'hA5A55A5A, 1'b0};
        tbl[14] = '{1'b0, 32'h80020010, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[15] = '{1'b1, 32'h80020010, 32'h0,        32'hCAFEF00D, 1'b0};

        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_ready",      32'(ready2), 32'd1);
        chk("rst_resp_valid", 32'(rv2),    32'd0);
        chk("rst_data",       dout2,       32'd0);
        chk("rst_err",        32'(err2),   32'd0);
        chk("rst_count",      cnt2,        32'd0);

        // Table-driven accesses: legal, illegal, boundary words
        for (int i = 0; i < 16; i++) begin
            do_req(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].exp_data, tbl[i].exp_err);
        end
        drain();
        chk("count_after_table", cnt2, 32'(exp_cnt));

        // Output holds last response
        repeat (3) @(negedge clock);
        chk("hold_data", dout2,     32'hCAFEF00D);
        chk("hold_err",  32'(err2), 32'd0);

        // Back-to-back: valid held 10 cycles
        @(negedge clock);
        rw = 1'b1; addr = 32'h80020000; req_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            chk("thru_ready", 32'(ready2), (i % 3 == 0) ? 32'd1 : 32'd0);
            if (ready2) begin
                sb.push_back('{32'hDEADBEEF, 1'b0, cyc + 1});
                acc++;
                exp_cnt++;
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        chk("thru_accepts", 32'(acc), 32'd4);
        drain();
        chk("thru_count", cnt2, 32'(exp_cnt));

        // Reset one cycle after acceptance drops the write
        @(negedge clock);
        rw = 1'b0; addr = 32'h80020010; wdata = 32'h12345678; req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_cnt = 0;
        rc = resp_cnt;
        repeat (6) @(negedge clock);
        chk("rst_drop_no_resp", 32'(resp_cnt), 32'(rc));
        chk("rst_drop_count",   cnt2,          32'd0);
        chk("rst_drop_ready",   32'(ready2),   32'd1);
        do_req(1'b1, 32'h80020010, 32'h0, 32'hCAFEF00D, 1'b0);
        drain();

        // Latency 1 / 4 instances
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_cnt = 0;
        do_req(1'b0, 32'h80020020, 32'h5A5A0001, 32'h0, 1'b0);
        drain();
        repeat (4) @(negedge clock);
        do_req(1'b1, 32'h80020020, 32'h0, 32'h5A5A0001, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            chk("lat1_valid", 32'(rv1), (k == 1) ? 32'd1 : 32'd0);
            chk("lat4_valid", 32'(rv4), (k == 4) ? 32'd1 : 32'd0);
            if (k == 1) begin
                chk("lat1_data", dout1,     32'h5A5A0001);
                chk("lat1_err",  32'(err1), 32'd0);
            end
            if (k == 4) begin
                chk("lat4_data", dout4,     32'h5A5A0001);
                chk("lat4_err",  32'(err4), 32'd0);
            end
        end
        drain();
        chk("lat1_count", cnt1,        32'd2);
        chk("lat4_count", cnt4,        32'd2);
        chk("lat2_count", cnt2,        32'(exp_cnt));
        chk("lat1_ready", 32'(ready1), 32'd1);
        chk("lat4_ready", 32'(ready4), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h80020000: byte address mapped to word index 0.
REQ-002 Parameter DEPTH_WORDS, default 256: number of 32-bit storage words.
REQ-003 Parameter LATENCY, default 2, legal range 1..4: cycles from request acceptance to response.
REQ-004 clock  input  1: single clock; all state changes on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 w_req_valid  input  1: requester presents a request.
REQ-007 w_req_ready  output  1: responder can accept a request this cycle.
REQ-008 w_rw  input  1: access type; 0 = write, 1 = read.
REQ-009 w_addr_32  input  32: byte address of the access.
REQ-010 w_data_in_32  input  32: write data.
REQ-011 w_resp_valid  output  1: one-cycle response strobe.
REQ-012 w_data_out_32  output  32: read data for the response.
REQ-013 w_err  output  1: the responded request was illegal; qualified by w_resp_valid.
REQ-014 w_req_count_32  output  32: count of accepted requests.

Function
REQ-015 The block SHALL implement two states, IDLE and WAIT; w_req_ready SHALL be 1 exactly when the state is IDLE.
REQ-016 A request SHALL be accepted at a rising edge where w_req_valid=1 and w_req_ready=1; at that edge the block latches w_rw, w_addr_32 and w_data_in_32, moves to WAIT, and loads a latency counter with LATENCY-1.
REQ-017 In WAIT, the counter SHALL decrement at each edge while it is nonzero; at the edge where it equals 0, the access SHALL complete and the state SHALL return to IDLE.
REQ-018 A request accepted at edge E0 SHALL produce w_resp_valid=1 for exactly the one cycle after edge E_LATENCY; w_req_ready SHALL also be 1 in that cycle.
REQ-019 Throughput SHALL be at most one request per LATENCY+1 cycles.
REQ-020 While in WAIT, input changes SHALL be ignored.
REQ-021 Index SHALL equal (latched address - BASE_ADDR) >> 2, computed modulo 2^32.
REQ-022 A request SHALL be illegal if address bits [1:0] are nonzero or if index >= DEPTH_WORDS; this includes addresses below BASE_ADDR, which wrap to a large index.
REQ-023 On completion of a legal write, storage[index] SHALL be updated; on response, w_data_out_32=0 and w_err=0.
REQ-024 On completion of a legal read, w_data_out_32 SHALL be storage[index] as of the completion edge; w_err=0.
REQ-025 On completion of an illegal request, storage SHALL be unchanged, w_data_out_32=0 and w_err=1.
REQ-026 A read accepted after a write response SHALL return the newly written data.
REQ-027 w_data_out_32 and w_err SHALL hold their last response values until the next response.
REQ-028 w_req_count_32 SHALL increment by 1 at each acceptance, legal or illegal, and wrap from 32'hFFFFFFFF to 0.

Reset
REQ-029 While reset=1 at an edge, the block SHALL go to IDLE with counter=0, w_resp_valid=0, w_data_out_32=0, w_err=0 and w_req_count_32=0; reset SHALL take priority over acceptance.
REQ-030 A reset during WAIT SHALL drop the in-flight request: no storage write and no response.
REQ-031 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-032 Bench SHALL cover: write addr 32'h80020000 data 32'hDEADBEEF, then read the same address -> write response err=0 and data 0; read response data 32'hDEADBEEF exactly 2 cycles after acceptance.
REQ-033 Bench SHALL cover: w_req_valid held at 1 for 10 cycles with LATENCY=2 -> exactly 3 or 4 acceptances with w_req_ready pattern 1,0,0,1,...; w_req_count_32 matches the number of acceptances.
REQ-034 Bench SHALL cover: read 32'h80020002 (misaligned), 32'h80020400 (index 256) and 32'h8001FFFC (below base) -> each response has err=1 and data 0; storage is unchanged.
REQ-035 Bench SHALL cover: write 32'h12345678 to 32'h80020010, with reset asserted one cycle after acceptance -> no response, and a subsequent read of 32'h80020010 returns the prior value.
REQ-036 Bench SHALL cover: LATENCY=1 and LATENCY=4 builds -> w_resp_valid appears 1 and 4 cycles after acceptance respectively, each for one cycle.
REQ-037 Bench SHALL cover: write the last word 32'h800203FC -> legal, and read-back matches.
